lcd_cmd_issuer: RTL and testbench
=================================

LCD_CMD_ISSUER -- requirements
Module: lcd_cmd_issuer

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge system clock.
REQ-002 SHALL have: reset  in  1  asynchronous, active-high reset.
REQ-003 SHALL have: in_cmd  in  4  host command code.
REQ-004 SHALL have: in_valid  in  1  host push request.
REQ-005 SHALL have: in_ready  out  1  FIFO not full; push accepted when in_valid&in_ready at clk rise.
REQ-006 SHALL have: cmd  out  4  command to LCD_CTRL.
REQ-007 SHALL have: cmd_valid  out  1  one-cycle issue strobe to LCD_CTRL.
REQ-008 SHALL have: busy  in  1  LCD_CTRL busy.
REQ-009 SHALL have: done  in  1  LCD_CTRL frame written to IRAM.
REQ-010 SHALL have: frame_done  out  1  one-cycle pulse after done is seen for an issued Write.
REQ-011 SHALL have: drop_err  out  1  sticky; illegal code (12..15) was pushed.
REQ-012 SHALL have: fifo_level  out  4  entries held, 0..8.
REQ-013 SHALL have, only with LCD_CMD_STAT_EN: issued_cnt  out  8  commands issued since reset.

Function
REQ-014 SHALL buffer commands in an 8-entry FIFO; in_ready = (fifo_level != 8).
REQ-015 SHALL discard pushes with in_cmd >= 12 (not stored), set drop_err, and keep it set until reset.
REQ-016 SHALL handle simultaneous push and pop: level unchanged, ordering preserved.
REQ-017 SHALL use FSM states IDLE, ISSUE, HOLD, WAIT_DONE.
REQ-018 IDLE: if FIFO is non-empty and busy=0, SHALL pop the head, drive cmd, set cmd_valid=1, and go to ISSUE.
REQ-019 ISSUE: SHALL clear cmd_valid next cycle, so cmd_valid is never high on two consecutive cycles; cmd is held stable while cmd_valid=1.
REQ-020 ISSUE: SHALL go to WAIT_DONE if the issued code is 0 (Write), else to HOLD.
REQ-021 HOLD: SHALL return to IDLE on the first cycle busy=0 (busy is sampled only from HOLD onward).
REQ-022 WAIT_DONE: SHALL ignore the FIFO until done=1, then pulse frame_done for one cycle and go to IDLE.
REQ-023 SHALL ignore done in states other than WAIT_DONE.
REQ-024 SHALL ensure issue latency from an empty FIFO is 1 cycle: pushed at edge N, cmd_valid high after edge N+1 if busy=0.
REQ-025 SHALL keep pushes accepted in every state, including WAIT_DONE.
REQ-026 SHALL drive all outputs from registers except in_ready and fifo_level.

Reset
REQ-027 SHALL, while reset=1, immediately clear: state=IDLE, FIFO empty, fifo_level=0, cmd=0, cmd_valid=0, frame_done=0, drop_err=0, issued_cnt=0.
REQ-028 SHALL, on reset mid-issue or in WAIT_DONE, abandon the command and flush the FIFO with no further strobes.
REQ-029 SHALL resume operation on the first clk rise after reset deasserts.

Configuration
REQ-030 SHALL define macro LCD_CMD_STAT_EN. When defined, issued_cnt increments on each cmd_valid strobe and wraps 255->0. When undefined, the port and its counter are absent and all other behaviour is identical.

Verification
REQ-031 SHALL cover: push 3,4,0 with busy held 0 two cycles after each strobe -> cmd_valid pulses carry 3, 4, 0 in order; no strobe until done; done=1 -> frame_done pulses once.
REQ-032 SHALL cover: push 9 pushes with no pops (busy=1) -> in_ready=0 at level 8; the 9th push is ignored; level stays 8.
REQ-033 SHALL cover: push 13 -> FIFO stays empty, drop_err=1 and stays 1; a following push 5 issues normally.
REQ-034 SHALL cover: busy held 1 for 20 cycles after a strobe -> no second strobe until 1 cycle after busy falls.
REQ-035 SHALL cover: reset asserted while in WAIT_DONE with 4 entries queued -> level=0, cmd_valid=0, and a later done produces no frame_done.
REQ-036 SHALL cover, with LCD_CMD_STAT_EN: issue 257 commands -> issued_cnt=1.

Source files
------------

// File: rtl/lcd_cmd_issuer.sv
// Command issuer: 8-deep FIFO of host codes feeding LCD_CTRL one strobe at a time.
// Optional LCD_CMD_STAT_EN adds the issued_cnt statistics port.
module lcd_cmd_issuer (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] in_cmd,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [3:0] cmd,
    output logic       cmd_valid,
    input  logic       busy,
    input  logic       done,
    output logic       frame_done,
    output logic       drop_err,
    output logic [3:0] fifo_level
`ifdef LCD_CMD_STAT_EN
    ,
    output logic [7:0] issued_cnt
`endif
);

    typedef enum logic [1:0] {IDLE, ISSUE, HOLD, WAIT_DONE} state_t;

    state_t     state, state_next;
    logic [3:0] mem [8];
    logic [2:0] wr_ptr, rd_ptr;
    logic [3:0] count;
    logic       legal, push, pop, frame_next;

    assign in_ready   = (count != 4'd8);
    assign fifo_level = count;
    assign legal      = (in_cmd < 4'd12);
    assign push       = in_valid && in_ready && legal;

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        frame_next = 1'b0;
        case (state)
            IDLE: begin
                if (count != '0 && !busy) begin
                    pop        = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE:     state_next = (cmd == '0) ? WAIT_DONE : HOLD;
            HOLD: begin
                if (!busy) state_next = IDLE;
            end
            WAIT_DONE: begin
                if (done) begin
                    frame_next = 1'b1;
                    state_next = IDLE;
                end
            end
            default:   state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Storage is not reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= in_cmd;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            cmd        <= '0;
            cmd_valid  <= 1'b0;
            frame_done <= 1'b0;
            drop_err   <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 3'd1;
            if (pop) begin
                rd_ptr <= rd_ptr + 3'd1;
                cmd    <= mem[rd_ptr];
            end
            case ({push, pop})
                2'b10:   count <= count + 4'd1;
                2'b01:   count <= count - 4'd1;
                default: count <= count;
            endcase
            cmd_valid  <= pop;
            frame_done <= frame_next;
            if (in_valid && in_ready && !legal) drop_err <= 1'b1;
        end
    end

`ifdef LCD_CMD_STAT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)    issued_cnt <= '0;
        else if (pop) issued_cnt <= issued_cnt + 8'd1;
    end
`endif

endmodule

// File: tb/tb_lcd_cmd_issuer.sv
// Scoreboard bench for lcd_cmd_issuer: a queue-based reference of the command
// flow predicts every strobe, frame_done pulse, FIFO level and error flag.
module tb_lcd_cmd_issuer;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] in_cmd;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] cmd;
    logic       cmd_valid;
    logic       busy;
    logic       done;
    logic       frame_done;
    logic       drop_err;
    logic [3:0] fifo_level;
`ifdef LCD_CMD_STAT_EN
    logic [7:0] issued_cnt;
`endif

    lcd_cmd_issuer dut (
        .clk        (clk),
        .reset      (reset),
        .in_cmd     (in_cmd),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .cmd        (cmd),
        .cmd_valid  (cmd_valid),
        .busy       (busy),
        .done       (done),
        .frame_done (frame_done),
        .drop_err   (drop_err),
        .fifo_level (fifo_level)
`ifdef LCD_CMD_STAT_EN
        ,
        .issued_cnt (issued_cnt)
`endif
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    function void check(string name, int act, int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference: pending commands, plus which phase of the handshake with LCD_CTRL
    // the last issued command is in (just strobed, waiting on busy, waiting on done).
    int          q[$];
    bit          m_drop;
    bit          m_just_issued;
    bit          m_await_busy;
    bit          m_await_done;
    int          m_last;
    int unsigned m_cnt;

    always @(posedge clk) begin
        bit   pre_rst, pre_v, pre_b, pre_d;
        int   pre_c, pre_size, exp_cmd;
        bit   exp_strobe, exp_frame;
        pre_rst    = reset;
        pre_v      = in_valid;
        pre_c      = int'(in_cmd);
        pre_b      = busy;
        pre_d      = done;
        pre_size   = q.size();
        exp_strobe = 1'b0;
        exp_frame  = 1'b0;
        exp_cmd    = 0;
        if (pre_rst) begin
            q.delete();
            m_drop        = 1'b0;
            m_just_issued = 1'b0;
            m_await_busy  = 1'b0;
            m_await_done  = 1'b0;
            m_cnt         = 0;
        end else begin
            check("in_ready", int'(in_ready), int'(pre_size != 8));
            if (m_just_issued) begin
                m_just_issued = 1'b0;
                if (m_last == 0) m_await_done = 1'b1;
                else             m_await_busy = 1'b1;
            end else if (m_await_busy) begin
                if (!pre_b) m_await_busy = 1'b0;
            end else if (m_await_done) begin
                if (pre_d) begin
                    m_await_done = 1'b0;
                    exp_frame    = 1'b1;
                end
            end else if (pre_size > 0 && !pre_b) begin
                exp_strobe    = 1'b1;
                exp_cmd       = q.pop_front();
                m_last        = exp_cmd;
                m_just_issued = 1'b1;
                m_cnt         = (m_cnt + 1) % 256;
            end
            if (pre_v && pre_size != 8) begin
                if (pre_c < 12) q.push_back(pre_c);
                else            m_drop = 1'b1;
            end
        end
        #1;
        check("cmd_valid", int'(cmd_valid), int'(exp_strobe));
        if (exp_strobe) check("cmd", int'(cmd), exp_cmd);
        if (pre_rst)    check("cmd_reset", int'(cmd), 0);
        check("frame_done", int'(frame_done), int'(exp_frame));
        check("drop_err", int'(drop_err), int'(m_drop));
        check("fifo_level", int'(fifo_level), q.size());
`ifdef LCD_CMD_STAT_EN
        check("issued_cnt", int'(issued_cnt), int'(m_cnt));
`endif
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_one(input logic [3:0] c);
        in_valid = 1'b1;
        in_cmd   = c;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Reset must clear the outputs immediately, not at the next clock edge.
    task automatic do_reset();
        reset    = 1'b1;
        in_valid = 1'b0;
        #1;
        check("rst_level", int'(fifo_level), 0);
        check("rst_cmd_valid", int'(cmd_valid), 0);
        check("rst_cmd", int'(cmd), 0);
        check("rst_frame_done", int'(frame_done), 0);
        check("rst_drop_err", int'(drop_err), 0);
        idle(2);
        reset = 1'b0;
    endtask

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        in_cmd   = '0;
        busy     = 1'b0;
        done     = 1'b0;
        @(negedge clk);
        do_reset();

        // Write sequence: 3, 4, then a Write that blocks until done.
        push_one(4'd3);
        push_one(4'd4);
        push_one(4'd0);
        idle(12);
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        idle(4);

        // Fill past capacity while LCD_CTRL is busy.
        busy     = 1'b1;
        in_valid = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            in_cmd = 4'(i);
            @(negedge clk);
        end
        in_valid = 1'b0;
        idle(3);
        check("full_level", int'(fifo_level), 8);
        check("full_ready", int'(in_ready), 0);
        busy = 1'b0;
        idle(40);

        // Illegal code is dropped, flag stays, next legal code issues.
        push_one(4'd13);
        idle(2);
        check("drop_level", int'(fifo_level), 0);
        push_one(4'd5);
        idle(6);
        check("drop_sticky", int'(drop_err), 1);

        // Long busy after a strobe holds off the next command.
        push_one(4'd6);
        push_one(4'd7);
        busy = 1'b1;
        idle(20);
        busy = 1'b0;
        idle(10);

        // Reset while waiting for done with four entries queued.
        push_one(4'd0);
        in_valid = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            in_cmd = 4'(i);
            @(negedge clk);
        end
        in_valid = 1'b0;
        idle(3);
        check("wait_level", int'(fifo_level), 4);
        do_reset();
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        idle(3);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            in_valid = ($urandom_range(0, 1) == 1);
            in_cmd   = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(12, 15))
                                                   : 4'($urandom_range(0, 11));
            busy     = ($urandom_range(0, 3) == 0);
            done     = ($urandom_range(0, 5) == 0);
            @(negedge clk);
        end
        in_valid = 1'b0;
        busy     = 1'b0;
        done     = 1'b1;
        idle(1);
        done = 1'b0;
        idle(30);

`ifdef LCD_CMD_STAT_EN
        do_reset();
        for (int i = 0; i < 257; i++) begin
            push_one(4'd1);
            idle(2);
        end
        idle(5);
        check("issued_wrap", int'(issued_cnt), 1);
`endif

        idle(2);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
